// File: rtl/seqrec_feed_ctrl.sv
// seqrec_feed_ctrl: feeds parallel words bit-serially to a sequence recognizer and collects its per-bit match map
module seqrec_feed_ctrl #(
  parameter int W = 8,
  parameter int Z_LAT = 0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             abort,
  output logic             X,
  input  logic             Z,
  output logic             rec_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [W-1:0]     match_map
);
  localparam int PW = $clog2(W);
  localparam logic [CNT_W-1:0] WM1 = CNT_W'(W - 1);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] sh, shl;
  logic [CNT_W-1:0] idx;
  logic [1:0] dcnt;
  logic [PW-1:0] curPos, smpP;
  logic lastSlot, kill, fb, smpV;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rec_clr = state == CLR;
  assign lastSlot = state == SHIFT && idx == WM1;
  assign kill = abort && busy && !done;
  assign fb = MSB_FIRST ? sh[W-1] : sh[0];
  assign shl = MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
  assign curPos = MSB_FIRST ? PW'(WM1 - idx) : PW'(idx);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = CLR;
      CLR:     nxt = SHIFT;
      SHIFT:   if (lastSlot) nxt = (Z_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (dcnt == 2'(Z_LAT - 1)) nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= IDLE;
    else state <= nxt;
  generate
    if (Z_LAT == 0) begin : g_direct
      assign smpV = state == SHIFT;
      assign smpP = curPos;
    end else begin : g_delay
      logic [Z_LAT-1:0] dv;
      logic [PW-1:0] dp [Z_LAT];
      always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) dv <= '0;
        else dv <= kill ? '0 : Z_LAT'({dv, state == SHIFT});
      always_ff @(posedge CLK) begin
        dp[0] <= curPos;
        for (int k = 1; k < Z_LAT; k++) dp[k] <= dp[k-1];
      end
      assign smpV = dv[Z_LAT-1];
      assign smpP = dp[Z_LAT-1];
    end
  endgenerate
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      sh <= '0;
      idx <= '0;
      dcnt <= '0;
      X <= 1'b0;
      match_cnt <= '0;
      match_map <= '0;
    end else begin
      sh <= (state == IDLE) ? in_data : shl;
      idx <= (state == SHIFT) ? idx + CNT_W'(1) : '0;
      dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      X <= !kill && (state == CLR || (state == SHIFT && !lastSlot)) && fb;
      if (state == IDLE && in_valid) begin
        match_cnt <= '0;
        match_map <= '0;
      end
      if (smpV && !kill) begin
        match_map[smpP] <= Z;
        match_cnt <= match_cnt + CNT_W'(Z);
      end
    end
endmodule

// File: tb/tb_seqrec_feed_ctrl.sv
// tb_seqrec_feed_ctrl: directed checks of the feed controller against bench "1101" recognizers
module tb_seqrec_feed_ctrl;
  logic CLK, nRESET;
  logic inValidA, inReadyA, abortA, xA, zA, recClrA, busyA, doneA;
  logic [7:0] inDataA, mapA;
  logic [3:0] cntA;
  logic inValidB, inReadyB, xB, zB, recClrB, busyB, doneB;
  logic [7:0] inDataB, mapB;
  logic [3:0] cntB;
  logic [1:0] sA;
  logic [2:0] sB;
  int vecs = 0;
  int miss = 0;
  seqrec_feed_ctrl #(.W(8), .Z_LAT(0), .MSB_FIRST(1'b1)) dutA (
    .CLK(CLK), .nRESET(nRESET), .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
    .abort(abortA), .X(xA), .Z(zA), .rec_clr(recClrA), .busy(busyA), .done(doneA),
    .match_cnt(cntA), .match_map(mapA));
  seqrec_feed_ctrl #(.W(8), .Z_LAT(2), .MSB_FIRST(1'b1)) dutB (
    .CLK(CLK), .nRESET(nRESET), .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
    .abort(1'b0), .X(xB), .Z(zB), .rec_clr(recClrB), .busy(busyB), .done(doneB),
    .match_cnt(cntB), .match_map(mapB));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK or negedge nRESET)
    if (!nRESET) sA <= 2'd0;
    else if (recClrA) sA <= 2'd0;
    else case (sA)
      2'd0: sA <= xA ? 2'd1 : 2'd0;
      2'd1: sA <= xA ? 2'd2 : 2'd0;
      2'd2: sA <= xA ? 2'd2 : 2'd3;
      default: sA <= xA ? 2'd1 : 2'd0;
    endcase
  assign zA = (sA == 2'd3) && xA;
  always @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      sB <= 3'd0;
      zB <= 1'b0;
    end else if (recClrB) begin
      sB <= 3'd0;
      zB <= 1'b0;
    end else begin
      zB <= sB == 3'd4;
      case (sB)
        3'd0: sB <= xB ? 3'd1 : 3'd0;
        3'd1: sB <= xB ? 3'd2 : 3'd0;
        3'd2: sB <= xB ? 3'd2 : 3'd3;
        3'd3: sB <= xB ? 3'd4 : 3'd0;
        default: sB <= xB ? 3'd2 : 3'd0;
      endcase
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic runWord(input logic [7:0] d, input logic hold, input logic [7:0] nextD,
                         input logic [7:0] expMap, input logic [3:0] expCnt);
    inValidA = 1'b1;
    inDataA = d;
    @(negedge CLK);
    chk("clr_pulse", recClrA, 1);
    chk("clr_x", xA, 0);
    chk("clr_ready", inReadyA, 0);
    inValidA = hold;
    inDataA = nextD;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("x_slot", xA, d[7-i]);
      chk("slot_clr_low", recClrA, 0);
      chk("slot_ready", inReadyA, 0);
      chk("slot_done", doneA, 0);
    end
    @(negedge CLK);
    chk("done", doneA, 1);
    chk("done_ready", inReadyA, 0);
    chk("done_x", xA, 0);
    chk("map", mapA, expMap);
    chk("cnt", cntA, expCnt);
    @(negedge CLK);
    chk("done_pulse", doneA, 0);
    chk("idle_ready", inReadyA, 1);
    chk("map_hold", mapA, expMap);
    chk("cnt_hold", cntA, expCnt);
  endtask
  initial begin
    nRESET = 1'b0;
    inValidA = 1'b0;
    inDataA = 8'h00;
    abortA = 1'b0;
    inValidB = 1'b0;
    inDataB = 8'h00;
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    chk("rst_ready", inReadyA, 1);
    chk("rst_busy", busyA, 0);
    chk("rst_x", xA, 0);
    chk("rst_clr", recClrA, 0);
    chk("rst_done", doneA, 0);
    chk("rst_map", mapA, 0);
    chk("rst_cnt", cntA, 0);
    chk("rst_readyB", inReadyB, 1);
    runWord(8'hDA, 1'b0, 8'h00, 8'h12, 4'd2);
    runWord(8'h06, 1'b0, 8'h00, 8'h00, 4'd0);
    runWord(8'h80, 1'b0, 8'h00, 8'h00, 4'd0);
    runWord(8'hDA, 1'b1, 8'h1B, 8'h12, 4'd2);
    runWord(8'h1B, 1'b0, 8'h00, 8'h02, 4'd1);
    inValidA = 1'b1;
    inDataA = 8'hDA;
    @(negedge CLK);
    inValidA = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort_busy", busyA, 1);
    chk("abort_pre_map", mapA, 8'h10);
    abortA = 1'b1;
    @(negedge CLK);
    abortA = 1'b0;
    chk("abort_idle", busyA, 0);
    chk("abort_ready", inReadyA, 1);
    chk("abort_x", xA, 0);
    chk("abort_done", doneA, 0);
    chk("abort_map", mapA, 8'h10);
    chk("abort_cnt", cntA, 1);
    @(negedge CLK);
    chk("abort_no_done", doneA, 0);
    chk("abort_map_hold", mapA, 8'h10);
    runWord(8'hDA, 1'b0, 8'h00, 8'h12, 4'd2);
    inValidA = 1'b1;
    inDataA = 8'hDA;
    @(negedge CLK);
    inValidA = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_mid_map", mapA, 8'h10);
    #2 nRESET = 1'b0;
    #1;
    chk("arst_busy", busyA, 0);
    chk("arst_ready", inReadyA, 1);
    chk("arst_x", xA, 0);
    chk("arst_done", doneA, 0);
    chk("arst_map", mapA, 0);
    chk("arst_cnt", cntA, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    chk("arst_rel_ready", inReadyA, 1);
    chk("arst_rel_busy", busyA, 0);
    inValidB = 1'b1;
    inDataB = 8'hDA;
    @(negedge CLK);
    chk("zl2_clr", recClrB, 1);
    inValidB = 1'b0;
    for (int k = 2; k < 12; k++) begin
      @(negedge CLK);
      chk("zl2_no_done", doneB, 0);
      chk("zl2_busy", busyB, 1);
    end
    @(negedge CLK);
    chk("zl2_done", doneB, 1);
    chk("zl2_map", mapB, 8'h12);
    chk("zl2_cnt", cntB, 2);
    @(negedge CLK);
    chk("zl2_pulse", doneB, 0);
    chk("zl2_ready", inReadyB, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
